uart_fifo: RTL and testbench

Parametrised next-generation UART peripheral with byte-addressed register interface, configurable character width and TX/RX FIFO buffering. Sits on the same 8-bit system register bus as the existing UART, but decouples software from line timing via FIFOs, adds sticky error flags, a FIFO level register and a level-sensitive interrupt. Self-contained: baud generator, transmitter, receiver, two FIFOs, register file.

---
 rtl/uart_fifo.sv | 374 +++++++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_fifo : UART with baud generator, TX/RX FIFOs, sticky error flags,   |
// |             level register and interrupt. Parity via UART_PARITY_EN.     |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+

module uart_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_pop_ok,
  output logic [CW-1:0]    o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;

  assign o_empty  = (count_q == '0);
  assign o_full   = (count_q == CW'(DEPTH));
  assign o_pop_ok = i_pop & ~o_empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle
  assign push_ok  = i_push & (~o_full | o_pop_ok);
  assign o_rdata  = mem_q[rd_ptr_q];
  assign o_count  = count_q;

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok)  wr_ptr_q <= wr_ptr_q + AW'(1);
      if (o_pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, o_pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

module uart_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_we,
  input  logic       i_re,
  input  logic [7:0] i_address,
  input  logic [7:0] i_data,
  input  logic       i_rx,
  output logic       o_tx,
  output logic [7:0] o_data,
  output logic       o_irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] ADDR_STATUS = 8'h00;
  localparam logic [7:0] ADDR_CTRL   = 8'h01;
  localparam logic [7:0] ADDR_BAUD_H = 8'h02;
  localparam logic [7:0] ADDR_BAUD_L = 8'h03;
  localparam logic [7:0] ADDR_DATA   = 8'h04;
  localparam logic [7:0] ADDR_LEVEL  = 8'h05;
  localparam logic [2:0] LAST_BIT    = 3'(DATA_BITS - 1);
`ifdef UART_PARITY_EN
  localparam logic PARITY_IMPL = 1'b1;
`else
  localparam logic PARITY_IMPL = 1'b0;
`endif
  localparam logic [6:0] CTRL_MASK = {PARITY_IMPL, PARITY_IMPL, 5'h1F};

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  logic wr_status, wr_ctrl, wr_baud_h, wr_baud_l, wr_data, rd_pop;
  assign wr_status = i_we & (i_address == ADDR_STATUS);
  assign wr_ctrl   = i_we & (i_address == ADDR_CTRL);
  assign wr_baud_h = i_we & (i_address == ADDR_BAUD_H);
  assign wr_baud_l = i_we & (i_address == ADDR_BAUD_L);
  assign wr_data   = i_we & (i_address == ADDR_DATA);
  assign rd_pop    = i_re & (i_address == ADDR_DATA);

  logic [6:0]  ctrl_q;
  logic [15:0] divisor_q;
  logic [15:0] baud_cnt_q;
  logic        tick;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl_q    <= '0;
      divisor_q <= '0;
    end else begin
      if (wr_ctrl)   ctrl_q          <= i_data[6:0] & CTRL_MASK;
      if (wr_baud_h) divisor_q[15:8] <= i_data;
      if (wr_baud_l) divisor_q[7:0]  <= i_data;
    end
  end

  assign tick = (baud_cnt_q >= divisor_q);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                    baud_cnt_q <= '0;
    else if (wr_baud_h || wr_baud_l) baud_cnt_q <= '0;
    else if (tick)                   baud_cnt_q <= '0;
    else                             baud_cnt_q <= baud_cnt_q + 16'd1;
  end

  // FIFOs
  logic [DATA_BITS-1:0] tx_head, rx_head;
  logic                 tx_empty, tx_full, tx_pop, tx_pop_ok;
  logic                 rx_empty, rx_full, rx_pop_ok, rx_push_q;
  logic [CW-1:0]        tx_count, rx_count;
  logic [DATA_BITS-1:0] rx_shift_q;

  uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH), .CW(CW)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (wr_data),
    .i_wdata (i_data[DATA_BITS-1:0]),
    .i_pop   (tx_pop),
    .o_rdata (tx_head),
    .o_empty (tx_empty),
    .o_full  (tx_full),
    .o_pop_ok(tx_pop_ok),
    .o_count (tx_count)
  );

  uart_fifo_buf #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH), .CW(CW)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (rx_push_q),
    .i_wdata (rx_shift_q),
    .i_pop   (rd_pop),
    .o_rdata (rx_head),
    .o_empty (rx_empty),
    .o_full  (rx_full),
    .o_pop_ok(rx_pop_ok),
    .o_count (rx_count)
  );

  // Transmitter: frames only start on a tick so every bit is exactly 16 ticks
  tx_state_t            tx_state_q;
  logic [3:0]           tx_tick_q;
  logic [2:0]           tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_par_q, tx_stop2_q, tx_q;
  logic                 tx_idle;

  assign tx_pop  = (tx_state_q == TX_IDLE) & tick & ctrl_q[0] & ~tx_empty;
  assign tx_idle = (tx_state_q == TX_IDLE) & tx_empty;
  assign o_tx    = tx_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_stop2_q <= 1'b0;
      tx_q       <= 1'b1;
    end else if (tick) begin
      if (tx_state_q == TX_IDLE) begin
        if (tx_pop_ok) begin
          tx_state_q <= TX_START;
          tx_tick_q  <= '0;
          tx_shift_q <= tx_head;
          tx_par_q   <= (^tx_head) ^ ctrl_q[6];
          tx_q       <= 1'b0;
        end
      end else begin
        tx_tick_q <= tx_tick_q + 4'd1;
        if (tx_tick_q == 4'd15) begin
          case (tx_state_q)
            TX_START: begin
              tx_state_q <= TX_DATA;
              tx_bit_q   <= '0;
              tx_q       <= tx_shift_q[0];
            end
            TX_DATA: begin
              if (tx_bit_q == LAST_BIT) begin
                if (PARITY_IMPL & ctrl_q[5]) begin
                  tx_state_q <= TX_PARITY;
                  tx_q       <= tx_par_q;
                end else begin
                  tx_state_q <= TX_STOP;
                  tx_stop2_q <= 1'b0;
                  tx_q       <= 1'b1;
                end
              end else begin
                tx_bit_q   <= tx_bit_q + 3'd1;
                tx_shift_q <= tx_shift_q >> 1;
                tx_q       <= tx_shift_q[1];
              end
            end
            TX_PARITY: begin
              tx_state_q <= TX_STOP;
              tx_stop2_q <= 1'b0;
              tx_q       <= 1'b1;
            end
            TX_STOP: begin
              if (ctrl_q[4] && !tx_stop2_q) tx_stop2_q <= 1'b1;
              else                          tx_state_q <= TX_IDLE;
            end
            default: begin
              tx_state_q <= TX_IDLE;
              tx_q       <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  // Receiver
  rx_state_t  rx_state_q;
  logic       rx_meta_q, rx_sync_q, rx_prev_q;
  logic [3:0] rx_tick_q;
  logic [2:0] rx_bit_q;
  logic       rx_par_bit_q, rx_ferr_q, rx_perr_q;
  logic       rx_par_bad;

  assign rx_par_bad = PARITY_IMPL & ctrl_q[5] &
                      (rx_par_bit_q != ((^rx_shift_q) ^ ctrl_q[6]));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_state_q   <= RX_IDLE;
      rx_tick_q    <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_bit_q <= 1'b0;
      rx_push_q    <= 1'b0;
      rx_ferr_q    <= 1'b0;
      rx_perr_q    <= 1'b0;
    end else begin
      rx_push_q <= 1'b0;
      rx_ferr_q <= 1'b0;
      rx_perr_q <= 1'b0;
      if (!ctrl_q[1]) begin
        rx_state_q <= RX_IDLE;
      end else if (rx_state_q == RX_IDLE) begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_q <= RX_START;
          rx_tick_q  <= '0;
        end
      end else if (tick) begin
        rx_tick_q <= rx_tick_q + 4'd1;
        if (rx_tick_q == 4'd7) begin
          case (rx_state_q)
            RX_START:  if (rx_sync_q) rx_state_q <= RX_IDLE;
            RX_DATA:   rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
            RX_PARITY: rx_par_bit_q <= rx_sync_q;
            RX_STOP: begin
              // Return to IDLE mid-stop so a following start edge is not missed
              rx_state_q <= RX_IDLE;
              rx_ferr_q  <= ~rx_sync_q;
              rx_perr_q  <= rx_par_bad;
              rx_push_q  <= rx_sync_q & ~rx_par_bad;
            end
            default: rx_state_q <= RX_IDLE;
          endcase
        end else if (rx_tick_q == 4'd15) begin
          case (rx_state_q)
            RX_START: begin
              rx_state_q <= RX_DATA;
              rx_bit_q   <= '0;
            end
            RX_DATA: begin
              if (rx_bit_q == LAST_BIT)
                rx_state_q <= (PARITY_IMPL & ctrl_q[5]) ? RX_PARITY : RX_STOP;
              else
                rx_bit_q <= rx_bit_q + 3'd1;
            end
            RX_PARITY: rx_state_q <= RX_STOP;
            default:   rx_state_q <= rx_state_q;
          endcase
        end
      end
    end
  end

  // Sticky flags: a set in the same cycle as a write-1-clear wins
  logic overrun_q, frame_err_q, parity_err, irq_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      overrun_q   <= (rx_push_q & rx_full & ~rx_pop_ok) |
                     (overrun_q & ~(wr_status & i_data[3]));
      frame_err_q <= rx_ferr_q | (frame_err_q & ~(wr_status & i_data[4]));
      irq_q       <= (ctrl_q[2] & ~rx_empty) | (ctrl_q[3] & tx_empty);
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) parity_err <= 1'b0;
    else          parity_err <= rx_perr_q | (parity_err & ~(wr_status & i_data[5]));
  end
`else
  assign parity_err = rx_perr_q & PARITY_IMPL;
`endif

  assign o_irq = irq_q;

  function automatic logic [3:0] sat15(input logic [CW-1:0] c);
    logic [7:0] ext;
    ext = 8'(c);
    return (ext > 8'd15) ? 4'hF : ext[3:0];
  endfunction

  always_comb begin
    o_data = 8'h00;
    case (i_address)
      ADDR_STATUS: o_data = {2'b00, parity_err, frame_err_q, overrun_q,
                             tx_idle, tx_full, ~rx_empty};
      ADDR_CTRL:   o_data = {1'b0, ctrl_q};
      ADDR_BAUD_H: o_data = divisor_q[15:8];
      ADDR_BAUD_L: o_data = divisor_q[7:0];
      ADDR_DATA:   o_data = rx_empty ? 8'h00 : 8'(rx_head);
      ADDR_LEVEL:  o_data = {sat15(tx_count), sat15(rx_count)};
      default:     o_data = 8'h00;
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_fifo : directed self-checking bench for uart_fifo (depth 4).     |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_uart_fifo;
  localparam int BIT = 64;  // 16 * (D + 1) with D = 3

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we = 1'b0, re = 1'b0;
  logic [7:0] addr = 8'h00, wdata = 8'h00;
  logic       rx_drv = 1'b1, loop = 1'b0;
  logic       rx_line, tx, irq;
  logic [7:0] rdata;
  int         tests_run = 0;
  int         fails = 0;

  assign rx_line = loop ? tx : rx_drv;
  always #5 clk = ~clk;

  uart_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_re(re), .i_address(addr),
    .i_data(wdata), .i_rx(rx_line), .o_tx(tx), .o_data(rdata), .o_irq(irq)
  );

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); addr = a; wdata = d; we = 1'b1;
    @(negedge clk); we = 1'b0; addr = 8'h00;
  endtask

  task automatic peek(input logic [7:0] a, output logic [7:0] v);
    addr = a; #1; v = rdata;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop, input logic with_par,
                         input logic par);
    @(negedge clk);
    rx_drv = 1'b0; repeat (BIT) @(negedge clk);
    for (int b = 0; b < 8; b++) begin rx_drv = d[b]; repeat (BIT) @(negedge clk); end
    if (with_par) begin rx_drv = par; repeat (BIT) @(negedge clk); end
    rx_drv = stop; repeat (BIT) @(negedge clk);
    rx_drv = 1'b1; repeat (BIT) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b expected 1", tx); end
    tests_run++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b expected 0", irq); end
    rst_n = 1'b1;
    @(negedge clk);
    peek(8'h00, v);
    tests_run++; if (v !== 8'h04) begin fails++; $display("FAIL reset_status: got %02h expected 04", v); end
    peek(8'h01, v);
    tests_run++; if (v !== 8'h00) begin fails++; $display("FAIL reset_ctrl: got %02h expected 00", v); end
    peek(8'h05, v);
    tests_run++; if (v !== 8'h00) begin fails++; $display("FAIL reset_level: got %02h expected 00", v); end
  endtask

  task automatic test_tx_frame();
    logic [7:0] v;
    logic [9:0] frame;
    logic       found;
    frame = {1'b1, 8'h55, 1'b0};
    wr(8'h01, 8'h01);
    wr(8'h04, 8'h55);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (tx === 1'b0) found = 1'b1; else @(negedge clk);
    end
    tests_run++; if (!found) begin fails++; $display("FAIL tx_start: got no start bit expected low within 50 clocks"); end
    for (int c = 0; c <= 165; c++) begin
      if (c < 160 && (c % 16 == 0 || c % 16 == 15)) begin
        tests_run++;
        if (tx !== frame[c/16]) begin
          fails++; $display("FAIL tx_bit clk %0d: got %b expected %b", c, tx, frame[c/16]);
        end
      end
      if (c == 8) begin
        peek(8'h00, v);
        tests_run++; if (v !== 8'h00) begin fails++; $display("FAIL tx_busy_status: got %02h expected 00", v); end
      end
      if (c == 165) begin
        peek(8'h00, v);
        tests_run++; if (v !== 8'h04) begin fails++; $display("FAIL tx_idle_status: got %02h expected 04", v); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] v;
    logic       found;
    loop = 1'b1;
    wr(8'h03, 8'h03);
    wr(8'h01, 8'h03);
    wr(8'h04, 8'hA3);
    wr(8'h04, 8'h0F);
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      peek(8'h05, v);
      if (v[3:0] == 4'd2) found = 1'b1; else @(negedge clk);
    end
    tests_run++; if (!found) begin fails++; $display("FAIL loop_wait: got rx count %0d expected 2", v[3:0]); end
    peek(8'h05, v);
    tests_run++; if (v !== 8'h02) begin fails++; $display("FAIL loop_level: got %02h expected 02", v); end
    @(negedge clk);
    addr = 8'h04; re = 1'b1; #1;
    tests_run++; if (rdata !== 8'hA3) begin fails++; $display("FAIL loop_data0: got %02h expected a3", rdata); end
    @(negedge clk); #1;
    tests_run++; if (rdata !== 8'h0F) begin fails++; $display("FAIL loop_data1: got %02h expected 0f", rdata); end
    @(negedge clk); re = 1'b0;
    repeat (100) @(negedge clk);
    peek(8'h00, v);
    tests_run++; if (v !== 8'h04) begin fails++; $display("FAIL loop_status: got %02h expected 04", v); end
    loop = 1'b0;
  endtask

  task automatic test_irq();
    wr(8'h01, 8'h0B);
    @(negedge clk);
    tests_run++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_tx_empty: got %b expected 1", irq); end
    wr(8'h01, 8'h03);
    @(negedge clk);
    tests_run++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_off: got %b expected 0", irq); end
  endtask

  task automatic test_overrun();
    logic [7:0] v;
    wr(8'h01, 8'h07);
    send_rx(8'h11, 1'b1, 1'b0, 1'b0);
    send_rx(8'h22, 1'b1, 1'b0, 1'b0);
    send_rx(8'h33, 1'b1, 1'b0, 1'b0);
    send_rx(8'h44, 1'b1, 1'b0, 1'b0);
    send_rx(8'h55, 1'b1, 1'b0, 1'b0);
    peek(8'h05, v);
    tests_run++; if (v !== 8'h04) begin fails++; $display("FAIL ovr_level: got %02h expected 04", v); end
    peek(8'h00, v);
    tests_run++; if (v !== 8'h0D) begin fails++; $display("FAIL ovr_status: got %02h expected 0d", v); end
    tests_run++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_rx_avail: got %b expected 1", irq); end
    wr(8'h00, 8'h08);
    peek(8'h00, v);
    tests_run++; if (v !== 8'h05) begin fails++; $display("FAIL ovr_clear: got %02h expected 05", v); end
    addr = 8'h04; re = 1'b1; #1;
    tests_run++; if (rdata !== 8'h11) begin fails++; $display("FAIL ovr_head: got %02h expected 11", rdata); end
    repeat (4) @(negedge clk);
    re = 1'b0;
    peek(8'h05, v);
    tests_run++; if (v !== 8'h00) begin fails++; $display("FAIL ovr_drain: got %02h expected 00", v); end
    peek(8'h04, v);
    tests_run++; if (v !== 8'h00) begin fails++; $display("FAIL empty_data: got %02h expected 00", v); end
    wr(8'h01, 8'h03);
  endtask

  task automatic test_frame_err();
    logic [7:0] v;
    send_rx(8'h81, 1'b0, 1'b0, 1'b0);
    peek(8'h00, v);
    tests_run++; if (v !== 8'h14) begin fails++; $display("FAIL ferr_status: got %02h expected 14", v); end
    peek(8'h05, v);
    tests_run++; if (v !== 8'h00) begin fails++; $display("FAIL ferr_level: got %02h expected 00", v); end
    wr(8'h00, 8'h10);
    peek(8'h00, v);
    tests_run++; if (v !== 8'h04) begin fails++; $display("FAIL ferr_clear: got %02h expected 04", v); end
  endtask

  task automatic test_tx_full();
    logic [7:0] v;
    logic       found;
    wr(8'h01, 8'h00);
    for (int i = 1; i <= 5; i++) wr(8'h04, 8'(i));
    peek(8'h00, v);
    tests_run++; if (v !== 8'h02) begin fails++; $display("FAIL txfull_status: got %02h expected 02", v); end
    peek(8'h05, v);
    tests_run++; if (v !== 8'h40) begin fails++; $display("FAIL txfull_level: got %02h expected 40", v); end
    loop = 1'b1;
    wr(8'h01, 8'h03);
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      peek(8'h00, v);
      if (v == 8'h05) found = 1'b1; else @(negedge clk);
    end
    tests_run++; if (!found) begin fails++; $display("FAIL txfull_drain: got status %02h expected 05", v); end
    peek(8'h05, v);
    tests_run++; if (v !== 8'h04) begin fails++; $display("FAIL txfull_rx_level: got %02h expected 04", v); end
    addr = 8'h04; re = 1'b1; #1;
    tests_run++; if (rdata !== 8'h01) begin fails++; $display("FAIL txfull_head: got %02h expected 01", rdata); end
    @(negedge clk); #1;
    tests_run++; if (rdata !== 8'h02) begin fails++; $display("FAIL txfull_next: got %02h expected 02", rdata); end
    repeat (3) @(negedge clk);
    re = 1'b0;
    loop = 1'b0;
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    logic [7:0] v;
    logic       found;
    wr(8'h01, 8'h23);
    peek(8'h01, v);
    tests_run++; if (v !== 8'h23) begin fails++; $display("FAIL par_ctrl: got %02h expected 23", v); end
    wr(8'h04, 8'h07);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (tx === 1'b0) found = 1'b1; else @(negedge clk);
    end
    tests_run++; if (!found) begin fails++; $display("FAIL par_start: got no start bit expected low"); end
    for (int c = 0; c <= 700; c++) begin
      if (c == 96) begin
        tests_run++; if (tx !== 1'b1) begin fails++; $display("FAIL par_bit0: got %b expected 1", tx); end
      end
      if (c == 288) begin
        tests_run++; if (tx !== 1'b0) begin fails++; $display("FAIL par_bit3: got %b expected 0", tx); end
      end
      if (c == 608) begin
        tests_run++; if (tx !== 1'b1) begin fails++; $display("FAIL par_txbit: got %b expected 1", tx); end
      end
      if (c == 672) begin
        tests_run++; if (tx !== 1'b1) begin fails++; $display("FAIL par_stop: got %b expected 1", tx); end
      end
      @(negedge clk);
    end
    send_rx(8'h07, 1'b1, 1'b1, 1'b0);
    peek(8'h00, v);
    tests_run++; if (v !== 8'h24) begin fails++; $display("FAIL par_err: got %02h expected 24", v); end
    peek(8'h05, v);
    tests_run++; if (v !== 8'h00) begin fails++; $display("FAIL par_drop: got %02h expected 00", v); end
    wr(8'h00, 8'h20);
    send_rx(8'h07, 1'b1, 1'b1, 1'b1);
    peek(8'h00, v);
    tests_run++; if (v !== 8'h05) begin fails++; $display("FAIL par_good: got %02h expected 05", v); end
  endtask
`else
  task automatic test_ctrl_mask();
    logic [7:0] v;
    wr(8'h01, 8'h63);
    peek(8'h01, v);
    tests_run++; if (v !== 8'h03) begin fails++; $display("FAIL ctrl_mask: got %02h expected 03", v); end
  endtask
`endif

  initial begin
    test_reset();
    test_tx_frame();
    test_loopback();
    test_irq();
    test_overrun();
    test_frame_err();
    test_tx_full();
`ifdef UART_PARITY_EN
    test_parity();
`else
    test_ctrl_mask();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
`default_nettype wire
